// File: rtl/jts16_colmix_pkg.sv
// Shared definitions for the System 16 colour mixer: layer ranks, palette
// page prefixes, pixel field widths and the palette-word to RGB decode.
package jts16_colmix_pkg;

  localparam int PAL_AW = 11;
  localparam int CHAR_W = 7;
  localparam int SCR_W  = 11;
  localparam int OBJ_W  = 12;

  localparam logic TILE_PAGE = 1'b0;
  localparam logic OBJ_PAGE  = 1'b1;

  // Ranks are all distinct and nonzero, so rank 0 can mean "nothing opaque yet".
  localparam logic [3:0] RANK_SCR2_LO = 4'd2;
  localparam logic [3:0] RANK_SCR2_HI = 4'd8;
  localparam logic [3:0] RANK_SCR1_LO = 4'd4;
  localparam logic [3:0] RANK_SCR1_HI = 4'd10;
  localparam logic [3:0] RANK_CHAR_LO = 4'd6;
  localparam logic [3:0] RANK_CHAR_HI = 4'd14;
  localparam logic [3:0] RANK_OBJ0    = 4'd3;
  localparam logic [3:0] RANK_OBJ1    = 4'd7;
  localparam logic [3:0] RANK_OBJ2    = 4'd9;
  localparam logic [3:0] RANK_OBJ3    = 4'd12;

  function automatic logic [3:0] obj_rank(input logic [1:0] prio);
    logic [3:0] r;
    case (prio)
      2'd0:    r = RANK_OBJ0;
      2'd1:    r = RANK_OBJ1;
      2'd2:    r = RANK_OBJ2;
      default: r = RANK_OBJ3;
    endcase
    return r;
  endfunction

  // The bits 12..14 are the LSBs of each 5-bit channel; bit 15 is ignored.
  function automatic logic [14:0] pal2rgb(input logic [15:0] p);
    return {p[3:0], p[12], p[7:4], p[13], p[11:8], p[14]};
  endfunction

endpackage

// File: rtl/jtframe_dual_ram16.sv
// 16-bit dual-port RAM with byte writes on port A (CPU) and an independent
// combinational read on port B (video).
module jtframe_dual_ram16 #(
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [15:0]   data_a_i,
  input  logic [1:0]    we_a_i,
  input  logic          rd_a_i,
  output logic [15:0]   q_a_o,
  input  logic [AW-1:0] addr_b_i,
  output logic [15:0]   q_b_o
);

  logic [15:0] mem [0:(2**AW)-1];
  logic [15:0] q_a_q;

  // No reset on the array: palette contents survive a pipeline reset.
  always_ff @(posedge clk_i) begin
    if (we_a_i[0]) mem[addr_a_i][7:0]  <= data_a_i[7:0];
    if (we_a_i[1]) mem[addr_a_i][15:8] <= data_a_i[15:8];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       q_a_q <= '0;
    else if (rd_a_i) q_a_q <= mem[addr_a_i];
  end

  assign q_a_o = q_a_q;
  assign q_b_o = mem[addr_b_i];

endmodule

// File: rtl/jts16_colmix.sv
// Colour mixer: priority-selects the visible layer, looks it up in the
// palette RAM and outputs blank-gated 5-bit RGB two pixel enables later.
module jts16_colmix
  import jts16_colmix_pkg::*;
#(
  parameter int BLNK_DLY = 2  // must be >= 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pxl_cen,
  input  logic                LHBL,
  input  logic                LVBL,
  input  logic [CHAR_W-1:0]   char_pxl,
  input  logic [SCR_W-1:0]    scr1_pxl,
  input  logic [SCR_W-1:0]    scr2_pxl,
  input  logic [OBJ_W-1:0]    obj_pxl,
  input  logic [PAL_AW-1:0]   cpu_addr,
  input  logic [15:0]         cpu_dout,
  input  logic [1:0]          cpu_dsn,
  input  logic                cpu_rnw,
  input  logic                pal_cs,
  output logic [15:0]         pal_dout,
  output logic [4:0]          red,
  output logic [4:0]          green,
  output logic [4:0]          blue,
  output logic                LHBL_dly,
  output logic                LVBL_dly
);

  logic [PAL_AW-1:0]   addr_d, addr_q;
  logic [3:0]          rank_best;
  logic [14:0]         rgb_q;
  logic [15:0]         pal_vid;
  logic [BLNK_DLY-1:0] lhbl_q, lvbl_q;
  logic [1:0]          we_a;
  logic                rd_a;

  // Backdrop default is scr2's address, so an all-transparent pixel uses its colour 0.
  always_comb begin
    rank_best = 4'd0;
    addr_d    = {TILE_PAGE, scr2_pxl[9:0]};
    if (scr2_pxl[2:0] != 3'd0)
      rank_best = scr2_pxl[10] ? RANK_SCR2_HI : RANK_SCR2_LO;
    if (scr1_pxl[2:0] != 3'd0 &&
        (scr1_pxl[10] ? RANK_SCR1_HI : RANK_SCR1_LO) > rank_best) begin
      rank_best = scr1_pxl[10] ? RANK_SCR1_HI : RANK_SCR1_LO;
      addr_d    = {TILE_PAGE, scr1_pxl[9:0]};
    end
    if (char_pxl[2:0] != 3'd0 &&
        (char_pxl[6] ? RANK_CHAR_HI : RANK_CHAR_LO) > rank_best) begin
      rank_best = char_pxl[6] ? RANK_CHAR_HI : RANK_CHAR_LO;
      addr_d    = {TILE_PAGE, 4'b0, char_pxl[5:0]};
    end
    if (obj_pxl[3:0] != 4'd0 && obj_rank(obj_pxl[11:10]) > rank_best) begin
      rank_best = obj_rank(obj_pxl[11:10]);
      addr_d    = {OBJ_PAGE, obj_pxl[9:0]};
    end
  end

  // Palette read and RGB decode share one enable, giving two-enable latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rgb_q  <= '0;
      lhbl_q <= '0;
      lvbl_q <= '0;
    end else if (pxl_cen) begin
      addr_q <= addr_d;
      rgb_q  <= pal2rgb(pal_vid);
      lhbl_q <= {lhbl_q[BLNK_DLY-2:0], LHBL};
      lvbl_q <= {lvbl_q[BLNK_DLY-2:0], LVBL};
    end
  end

  assign we_a = (pal_cs && !cpu_rnw) ? ~cpu_dsn : 2'b00;
  assign rd_a = pal_cs && cpu_rnw;

  jtframe_dual_ram16 #(.AW(PAL_AW)) u_pal (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_a_i (cpu_addr),
    .data_a_i (cpu_dout),
    .we_a_i   (we_a),
    .rd_a_i   (rd_a),
    .q_a_o    (pal_dout),
    .addr_b_i (addr_q),
    .q_b_o    (pal_vid)
  );

  assign LHBL_dly = lhbl_q[BLNK_DLY-1];
  assign LVBL_dly = lvbl_q[BLNK_DLY-1];
  assign {red, green, blue} = (LHBL_dly && LVBL_dly) ? rgb_q : 15'd0;

endmodule

// File: tb/tb_jts16_colmix.sv
// Directed bench for jts16_colmix: CPU palette access, layer priority,
// backdrop, latency, blanking delay, same-clock write/read and mid-frame reset.
module tb_jts16_colmix;

  logic        clk = 1'b0;
  logic        rst, pxl_cen, LHBL, LVBL;
  logic [6:0]  char_pxl;
  logic [10:0] scr1_pxl, scr2_pxl;
  logic [11:0] obj_pxl;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_dout;
  logic [1:0]  cpu_dsn;
  logic        cpu_rnw, pal_cs;
  logic [15:0] pal_dout;
  logic [4:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jts16_colmix #(.BLNK_DLY(2)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .char_pxl(char_pxl), .scr1_pxl(scr1_pxl), .scr2_pxl(scr2_pxl),
    .obj_pxl(obj_pxl), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_dsn(cpu_dsn), .cpu_rnw(cpu_rnw), .pal_cs(pal_cs),
    .pal_dout(pal_dout), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix();
    pxl_cen = 1'b1;
    step();
    pxl_cen = 1'b0;
  endtask

  task automatic cpu_wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] dsn);
    cpu_addr = a; cpu_dout = d; cpu_dsn = dsn; cpu_rnw = 1'b0; pal_cs = 1'b1;
    step();
    pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_dsn = 2'b11;
  endtask

  task automatic cpu_rd(input logic [10:0] a);
    cpu_addr = a; cpu_rnw = 1'b1; pal_cs = 1'b1;
    step();
    pal_cs = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    char_pxl = '0; scr1_pxl = '0; scr2_pxl = '0; obj_pxl = '0;
    cpu_addr = '0; cpu_dout = '0; cpu_dsn = 2'b11; cpu_rnw = 1'b1; pal_cs = 1'b0;
    pxl_cen = 1'b1;
    step(); step();
    pxl_cen = 1'b0;
    check("reset_red", {11'd0, red}, 16'h0000);
    check("reset_lhbl_dly", {15'd0, LHBL_dly}, 16'h0000);
    check("reset_lvbl_dly", {15'd0, LVBL_dly}, 16'h0000);
    check("reset_pal_dout", pal_dout, 16'h0000);
    rst = 1'b0;
    step();

    // CPU port, all accesses with pxl_cen low
    cpu_wr(11'h013, 16'h7FFF, 2'b00);
    cpu_rd(11'h013);
    check("cpu_rd_7fff", pal_dout, 16'h7FFF);
    cpu_wr(11'h013, 16'hAB00, 2'b01);
    cpu_rd(11'h013);
    check("cpu_rd_upper_byte", pal_dout, 16'hABFF);
    cpu_wr(11'h01A, 16'h0002, 2'b00);
    cpu_wr(11'h005, 16'h0003, 2'b00);
    cpu_wr(11'h432, 16'h0004, 2'b00);
    cpu_wr(11'h0A8, 16'h0005, 2'b00);
    cpu_wr(11'h123, 16'h1234, 2'b00);
    cpu_wr(11'h050, 16'h0000, 2'b00);
    cpu_wr(11'h005, 16'hFFFF, 2'b11);
    cpu_rd(11'h005);
    check("cpu_dsn11_noop", pal_dout, 16'h0003);
    cpu_wr(11'h0A8, 16'h0705, 2'b10);
    cpu_rd(11'h0A8);
    check("cpu_lower_byte", pal_dout, 16'h0005);

    // Priority: obj prio1 (7) beats char prio0 (6); palette 0x432 = 0x0004 -> red 8
    scr2_pxl = 11'h013; scr1_pxl = 11'h01A; char_pxl = 7'h05; obj_pxl = 12'h432;
    pix(); pix();
    check("prio_obj_red", {11'd0, red}, 16'h0008);
    char_pxl = 7'h45;  // char prio1 (14) wins, address 0x005 = 0x0003 -> red 6
    pix(); pix();
    check("prio_char_red", {11'd0, red}, 16'h0006);
    scr1_pxl = 11'h41A; char_pxl = 7'h05; obj_pxl = 12'h032;  // scr1 prio1 (10) wins
    pix(); pix();
    check("prio_scr1_red", {11'd0, red}, 16'h0004);

    // Backdrop: all transparent -> scr2 address 0x0A8 = 0x0005 -> red 0x0A
    scr2_pxl = 11'h0A8; scr1_pxl = 11'h018; char_pxl = 7'h40; obj_pxl = 12'hC30;
    pix(); pix();
    check("backdrop_red", {11'd0, red}, 16'h000A);

    // Latency: 0x1234 -> red {4,1}=0x09, green {3,0}=0x06, blue {2,0}=0x04
    scr2_pxl = 11'h123;
    pix();
    check("latency_1cen_red", {11'd0, red}, 16'h000A);
    pix();
    check("latency_2cen_red", {11'd0, red}, 16'h0009);
    check("latency_2cen_green", {11'd0, green}, 16'h0006);
    check("latency_2cen_blue", {11'd0, blue}, 16'h0004);

    // Blanking delay
    LHBL = 1'b0;
    pix();
    LHBL = 1'b1;
    check("blank_a_lhbl_dly", {15'd0, LHBL_dly}, 16'h0001);
    pix();
    check("blank_b_lhbl_dly", {15'd0, LHBL_dly}, 16'h0000);
    check("blank_b_red", {11'd0, red}, 16'h0000);
    pix();
    check("blank_c_lhbl_dly", {15'd0, LHBL_dly}, 16'h0001);
    check("blank_c_red", {11'd0, red}, 16'h0009);

    // Same-clock CPU write and video read of 0x050
    scr2_pxl = 11'h050;
    pix();
    check("samclk_prev_red", {11'd0, red}, 16'h0009);
    cpu_addr = 11'h050; cpu_dout = 16'h001F; cpu_dsn = 2'b00; cpu_rnw = 1'b0;
    pal_cs = 1'b1; pxl_cen = 1'b1;
    step();
    pal_cs = 1'b0; pxl_cen = 1'b0; cpu_rnw = 1'b1; cpu_dsn = 2'b11;
    check("samclk_old_red", {11'd0, red}, 16'h0000);
    check("samclk_old_green", {11'd0, green}, 16'h0000);
    pix();
    check("samclk_new_red", {11'd0, red}, 16'h001E);
    check("samclk_new_green", {11'd0, green}, 16'h0002);

    // Mid-line reset
    scr2_pxl = 11'h123;
    pix(); pix();
    cpu_rd(11'h123);
    check("pre_rst_pal_dout", pal_dout, 16'h1234);
    check("pre_rst_red", {11'd0, red}, 16'h0009);
    rst = 1'b1;
    step();
    check("rst_red", {11'd0, red}, 16'h0000);
    check("rst_lhbl_dly", {15'd0, LHBL_dly}, 16'h0000);
    check("rst_lvbl_dly", {15'd0, LVBL_dly}, 16'h0000);
    check("rst_pal_dout", pal_dout, 16'h0000);
    rst = 1'b0;
    cpu_rd(11'h123);
    check("ram_retained", pal_dout, 16'h1234);
    pix();
    check("post_rst_1cen_red", {11'd0, red}, 16'h0000);
    pix();
    check("post_rst_2cen_red", {11'd0, red}, 16'h0009);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
